// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR with run-time seed load,
// step enable, all-zero load guard and a period-complete pulse.
module lfsr_gen #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] FIB_TAPS = 8'hB8,
    parameter logic [WIDTH-1:0] GAL_POLY = 8'h71,
    parameter logic [WIDTH-1:0] SEED     = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             period_done,
    output logic             lockup
);

    // Reference point for period detection: last accepted seed, or SEED.
    logic [WIDTH-1:0] ref_seed;
    logic [WIDTH-1:0] q_next;

    // Fibonacci feedback bit: parity of the tapped state bits.
    function automatic logic fib_fb(input logic [WIDTH-1:0] s);
        return ^(s & FIB_TAPS);
    endfunction

    // Galois next state: shift left, fold the polynomial in when the MSB falls out.
    function automatic logic [WIDTH-1:0] gal_next(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? GAL_POLY : '0);
    endfunction

    // Next-state selection; mode is looked at only when a step is taken.
    always_comb begin
        q_next = '0;
        if (mode) q_next = gal_next(q);
        else      q_next = {q[WIDTH-2:0], fib_fb(q)};
    end

    // State, reference seed and the two registered one-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q           <= SEED;
            ref_seed    <= SEED;
            period_done <= 1'b0;
            lockup      <= 1'b0;
        end else begin
            period_done <= 1'b0;
            lockup      <= 1'b0;
            if (load) begin
                // An all-zero load would freeze the register; fall back to SEED instead.
                if (seed_in != '0) begin
                    q        <= seed_in;
                    ref_seed <= seed_in;
                end else begin
                    q        <= SEED;
                    ref_seed <= SEED;
                    lockup   <= 1'b1;
                end
            end else if (en) begin
                q           <= q_next;
                period_done <= (q_next == ref_seed);
            end
        end
    end

    assign sout = q[WIDTH-1];

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed bench for lfsr_gen with default 8-bit masks.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic       load;
    logic [7:0] seed_in;
    logic [7:0] q;
    logic       sout;
    logic       period_done;
    logic       lockup;

    int checks   = 0;
    int failures = 0;

    lfsr_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .load        (load),
        .seed_in     (seed_in),
        .q           (q),
        .sout        (sout),
        .period_done (period_done),
        .lockup      (lockup)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one active edge, then settle to the following falling edge for sampling
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // reset pulse aligned to a falling edge, released on the next falling edge
    task automatic pulse_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int pulses;
        int pulse_step;
        int lk_pulses;
        int dups;
        int spurious;
        logic [255:0] seen;

        rst = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; seed_in = 8'h00;

        // ---- reset and hold ----
        #25;
        check("rst_q", q, 8'h01);
        check("rst_sout", sout, 1'b0);
        check("rst_pd", period_done, 1'b0);
        check("rst_lk", lockup, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (q !== 8'h01) pulses++;
            if (period_done !== 1'b0 || lockup !== 1'b0) pulses++;
        end
        check("hold_stable", pulses, 0);
        check("hold_q", q, 8'h01);

        // ---- Fibonacci stepping ----
        pulse_reset();
        mode = 1'b0; en = 1'b1;
        tick(); check("fib_s1", q, 8'h02);
        tick(); check("fib_s2", q, 8'h04);
        tick(); check("fib_s3", q, 8'h08);
        tick(); check("fib_s4", q, 8'h11);
        pulses = 0; pulse_step = 0;
        for (int k = 5; k <= 255; k++) begin
            tick();
            if (period_done) begin pulses++; pulse_step = k; end
        end
        check("fib_pulses", pulses, 1);
        check("fib_pulse_step", pulse_step, 255);
        check("fib_wrap_q", q, 8'h01);
        tick();
        check("fib_pd_one_cycle", period_done, 1'b0);
        check("fib_s256", q, 8'h02);

        // ---- Galois stepping ----
        pulse_reset();
        mode = 1'b1; en = 1'b1;
        seen = '0; dups = 0; pulses = 0; pulse_step = 0;
        seen[8'h01] = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (k <= 7) check($sformatf("gal_s%0d", k), q, 8'h01 << k);
            if (k == 7) check("gal_sout_msb", sout, 1'b1);
            if (k == 8) check("gal_s8", q, 8'h71);
            if (period_done) begin pulses++; pulse_step = k; end
            if (k < 255) begin
                if (seen[q] || q == 8'h00) dups++;
                seen[q] = 1'b1;
            end
        end
        check("gal_distinct", dups, 0);
        check("gal_pulses", pulses, 1);
        check("gal_pulse_step", pulse_step, 255);
        check("gal_wrap_q", q, 8'h01);

        // ---- seed load with en also high ----
        tick(); tick();
        load = 1'b1; seed_in = 8'h5A; en = 1'b1;
        tick();
        check("load_q", q, 8'h5A);
        check("load_no_pd", period_done, 1'b0);
        check("load_no_lk", lockup, 1'b0);
        load = 1'b0;
        pulses = 0; pulse_step = 0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (period_done) begin pulses++; pulse_step = k; end
        end
        check("load_pulses", pulses, 1);
        check("load_pulse_step", pulse_step, 255);
        check("load_wrap_q", q, 8'h5A);

        // ---- lock-up guard ----
        load = 1'b1; seed_in = 8'h00;
        tick();
        check("lk_q", q, 8'h01);
        check("lk_pulse", lockup, 1'b1);
        check("lk_sout", sout, 1'b0);
        load = 1'b0; en = 1'b0;
        tick();
        check("lk_one_cycle", lockup, 1'b0);
        check("lk_hold_q", q, 8'h01);
        mode = 1'b0; en = 1'b1;
        tick();
        check("lk_restart", q, 8'h02);
        lk_pulses = 0; pulses = 0;
        for (int k = 2; k <= 255; k++) begin
            tick();
            if (period_done) pulses++;
            if (lockup) lk_pulses++;
        end
        check("lk_ref_reset_pd", pulses, 1);
        check("lk_no_more", lk_pulses, 0);

        // ---- reset mid-run and mode switch ----
        pulse_reset();
        mode = 1'b0; en = 1'b1;
        spurious = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (period_done || lockup) spurious++;
        end
        #2 rst = 1'b0;
        #1;
        check("mid_rst_q", q, 8'h01);
        check("mid_rst_pd", period_done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick(); check("mid_s1", q, 8'h02);
        if (period_done || lockup) spurious++;
        tick(); check("mid_s2", q, 8'h04);
        if (period_done || lockup) spurious++;
        tick(); check("mid_s3", q, 8'h08);
        if (period_done || lockup) spurious++;
        mode = 1'b1;
        tick(); check("mid_gal", q, 8'h10);
        if (period_done || lockup) spurious++;
        check("mid_spurious", spurious, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
